// File: rtl/rob_pkg.sv
// Shared rename types: architectural/physical register widths, request structs, restore FSM states.
package rob_pkg;
  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int AW = $clog2(NUM_ARCH_REGS);
  localparam int PW = $clog2(NUM_PHYS_REGS);

  typedef logic [AW-1:0] areg_t;
  typedef logic [PW-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    logic  rd_we;
    areg_t rd_arch;
    preg_t rd_phys;
    areg_t rs1_arch;
    areg_t rs2_arch;
  } rename_req_t;

  typedef struct packed {
    logic  valid;
    areg_t arch;
    preg_t phys;
  } commit_req_t;

  typedef enum logic {RS_IDLE, RS_RESTORE} restore_state_e;
endpackage

// File: rtl/rename_map_table_if.sv
// Decode/commit/flush bundle of the rename map table; master = pipeline side, slave = map table.
interface rename_map_table_if
  import rob_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int CMT_WIDTH = 2
) ();
  logic [WIDTH-1:0]      ren_valid_i;
  logic [WIDTH-1:0]      ren_rd_we_i;
  areg_t [WIDTH-1:0]     ren_rd_arch_i;
  preg_t [WIDTH-1:0]     ren_rd_phys_i;
  areg_t [WIDTH-1:0]     ren_rs1_arch_i;
  areg_t [WIDTH-1:0]     ren_rs2_arch_i;
  logic [WIDTH-1:0]      ren_accept_o;
  logic [WIDTH-1:0]      ren_out_valid_o;
  preg_t [WIDTH-1:0]     ren_rs1_phys_o;
  preg_t [WIDTH-1:0]     ren_rs2_phys_o;
  preg_t [WIDTH-1:0]     ren_old_phys_o;
  logic [CMT_WIDTH-1:0]  cmt_valid_i;
  areg_t [CMT_WIDTH-1:0] cmt_arch_i;
  preg_t [CMT_WIDTH-1:0] cmt_phys_i;
  logic                  flush_i;
  logic                  restore_busy_o;

  modport master (
    output ren_valid_i, ren_rd_we_i, ren_rd_arch_i, ren_rd_phys_i, ren_rs1_arch_i, ren_rs2_arch_i,
    output cmt_valid_i, cmt_arch_i, cmt_phys_i, flush_i,
    input  ren_accept_o, ren_out_valid_o, ren_rs1_phys_o, ren_rs2_phys_o, ren_old_phys_o,
    input  restore_busy_o
  );

  modport slave (
    input  ren_valid_i, ren_rd_we_i, ren_rd_arch_i, ren_rd_phys_i, ren_rs1_arch_i, ren_rs2_arch_i,
    input  cmt_valid_i, cmt_arch_i, cmt_phys_i, flush_i,
    output ren_accept_o, ren_out_valid_o, ren_rs1_phys_o, ren_rs2_phys_o, ren_old_phys_o,
    output restore_busy_o
  );
endinterface

// File: rtl/rename_map_table_map_bank.sv
// Flop-based map array, reset to identity; NW write ports (higher index wins), NR async read ports.
module map_bank #(
  parameter int DEPTH = 32,
  parameter int DW    = 6,
  parameter int NW    = 1,
  parameter int NR    = 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NW-1:0]           we_i,
  input  logic [NW-1:0][AW-1:0]   waddr_i,
  input  logic [NW-1:0][DW-1:0]   wdata_i,
  input  logic [NR-1:0][AW-1:0]   raddr_i,
  output logic [NR-1:0][DW-1:0]   rdata_o
);
  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NW; w++)
      if (we_i[w]) mem_d[waddr_i[w]] = wdata_i[w];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DW'(i);
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    assign rdata_o[r] = mem_q[raddr_i[r]];
  end
endmodule

// File: rtl/rename_map_table.sv
// Speculative RAT + committed RRAT with multi-cycle flush restore.
// RENAME_INTRA_BYPASS_EN: intra-group override network; otherwise dependent slots are held back.
module rename_map_table #(
  parameter int NUM_ARCH_REGS = rob_pkg::NUM_ARCH_REGS,
  parameter int NUM_PHYS_REGS = rob_pkg::NUM_PHYS_REGS,
  parameter int WIDTH         = 2,
  parameter int CMT_WIDTH     = 2,
  parameter int RESTORE_LANES = 8
) (
  input  logic               clk,
  input  logic               rst,
  rename_map_table_if.slave  bus
);
  import rob_pkg::*;

  localparam int AW     = $clog2(NUM_ARCH_REGS);
  localparam int PW     = $clog2(NUM_PHYS_REGS);
  localparam int NBLK   = NUM_ARCH_REGS / RESTORE_LANES;
  localparam int BW     = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int RAT_NW = RESTORE_LANES + CMT_WIDTH + WIDTH;
  localparam int RAT_NR = 3 * WIDTH;

  rename_req_t [WIDTH-1:0]     req;
  commit_req_t [CMT_WIDTH-1:0] cmt;

  for (genvar s = 0; s < WIDTH; s++) begin : g_req
    assign req[s] = '{valid:    bus.ren_valid_i[s],
                      rd_we:    bus.ren_rd_we_i[s],
                      rd_arch:  bus.ren_rd_arch_i[s],
                      rd_phys:  bus.ren_rd_phys_i[s],
                      rs1_arch: bus.ren_rs1_arch_i[s],
                      rs2_arch: bus.ren_rs2_arch_i[s]};
  end
  for (genvar c = 0; c < CMT_WIDTH; c++) begin : g_cmt
    assign cmt[c] = '{valid: bus.cmt_valid_i[c], arch: bus.cmt_arch_i[c], phys: bus.cmt_phys_i[c]};
  end

  restore_state_e state_q, state_d;
  logic [BW-1:0]  blk_q, blk_d;
  logic           restoring, stall;

  logic [WIDTH-1:0]          accept;
  logic [WIDTH-1:0][PW-1:0]  rs1_map, rs2_map, old_map;
  logic [WIDTH-1:0]          out_valid_q, out_valid_d;
  logic [WIDTH-1:0][PW-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, old_q, old_d;

  logic [RAT_NW-1:0]                 rat_we;
  logic [RAT_NW-1:0][AW-1:0]         rat_waddr;
  logic [RAT_NW-1:0][PW-1:0]         rat_wdata;
  logic [RAT_NR-1:0][AW-1:0]         rat_raddr;
  logic [RAT_NR-1:0][PW-1:0]         rat_rdata;
  logic [CMT_WIDTH-1:0]              rrat_we;
  logic [CMT_WIDTH-1:0][AW-1:0]      rrat_waddr;
  logic [CMT_WIDTH-1:0][PW-1:0]      rrat_wdata;
  logic [RESTORE_LANES-1:0][AW-1:0]  rrat_raddr;
  logic [RESTORE_LANES-1:0][PW-1:0]  rrat_rdata;

  assign restoring = (state_q == RS_RESTORE);
  assign stall     = bus.flush_i | restoring;

  // Read ports: [0..W-1] rs1, [W..2W-1] rs2, [2W..3W-1] rd (old mapping).
  for (genvar s = 0; s < WIDTH; s++) begin : g_rd_addr
    assign rat_raddr[s]           = req[s].rs1_arch;
    assign rat_raddr[WIDTH+s]     = req[s].rs2_arch;
    assign rat_raddr[2*WIDTH+s]   = req[s].rd_arch;
  end

`ifdef RENAME_INTRA_BYPASS_EN
  always_comb begin
    accept  = '0;
    rs1_map = '0;
    rs2_map = '0;
    old_map = '0;
    for (int s = 0; s < WIDTH; s++) begin
      accept[s]  = req[s].valid & ~stall;
      rs1_map[s] = rat_rdata[s];
      rs2_map[s] = rat_rdata[WIDTH+s];
      old_map[s] = rat_rdata[2*WIDTH+s];
      // Later t overrides earlier, so the youngest older writer wins.
      for (int t = 0; t < s; t++) begin
        if (accept[t] && req[t].rd_we) begin
          if (req[t].rd_arch == req[s].rs1_arch) rs1_map[s] = req[t].rd_phys;
          if (req[t].rd_arch == req[s].rs2_arch) rs2_map[s] = req[t].rd_phys;
          if (req[t].rd_arch == req[s].rd_arch)  old_map[s] = req[t].rd_phys;
        end
      end
    end
  end
`else
  logic blocked;
  logic dep;

  always_comb begin
    accept  = '0;
    rs1_map = '0;
    rs2_map = '0;
    old_map = '0;
    blocked = 1'b0;
    dep     = 1'b0;
    for (int s = 0; s < WIDTH; s++) begin
      dep = 1'b0;
      for (int t = 0; t < s; t++) begin
        if (req[t].valid && req[t].rd_we &&
            ((req[t].rd_arch == req[s].rs1_arch) || (req[t].rd_arch == req[s].rs2_arch) ||
             (req[s].rd_we && (req[t].rd_arch == req[s].rd_arch))))
          dep = 1'b1;
      end
      // First dependent valid slot blocks itself and everything younger.
      blocked    = blocked | (req[s].valid & dep);
      accept[s]  = req[s].valid & ~stall & ~blocked;
      rs1_map[s] = rat_rdata[s];
      rs2_map[s] = rat_rdata[WIDTH+s];
      old_map[s] = rat_rdata[2*WIDTH+s];
    end
  end
`endif

  // RAT write ports, lowest priority first: restore copy, commits, renames.
  // A commit into the block being copied or an earlier one must land in the RAT too.
  always_comb begin
    rat_we     = '0;
    rat_waddr  = '0;
    rat_wdata  = '0;
    rrat_raddr = '0;
    for (int k = 0; k < RESTORE_LANES; k++) begin
      rrat_raddr[k] = AW'(int'(blk_q) * RESTORE_LANES + k);
      rat_we[k]     = restoring;
      rat_waddr[k]  = rrat_raddr[k];
      rat_wdata[k]  = rrat_rdata[k];
    end
    for (int c = 0; c < CMT_WIDTH; c++) begin
      rat_we[RESTORE_LANES+c]    = restoring & cmt[c].valid &
                                   (int'(cmt[c].arch) < (int'(blk_q) + 1) * RESTORE_LANES);
      rat_waddr[RESTORE_LANES+c] = cmt[c].arch;
      rat_wdata[RESTORE_LANES+c] = cmt[c].phys;
    end
    for (int s = 0; s < WIDTH; s++) begin
      rat_we[RESTORE_LANES+CMT_WIDTH+s]    = accept[s] & req[s].rd_we;
      rat_waddr[RESTORE_LANES+CMT_WIDTH+s] = req[s].rd_arch;
      rat_wdata[RESTORE_LANES+CMT_WIDTH+s] = req[s].rd_phys;
    end
  end

  for (genvar c = 0; c < CMT_WIDTH; c++) begin : g_rrat_wr
    assign rrat_we[c]    = cmt[c].valid;
    assign rrat_waddr[c] = cmt[c].arch;
    assign rrat_wdata[c] = cmt[c].phys;
  end

  map_bank #(.DEPTH(NUM_ARCH_REGS), .DW(PW), .NW(RAT_NW), .NR(RAT_NR), .AW(AW)) u_rat (
    .clk(clk), .rst(rst),
    .we_i(rat_we), .waddr_i(rat_waddr), .wdata_i(rat_wdata),
    .raddr_i(rat_raddr), .rdata_o(rat_rdata)
  );

  map_bank #(.DEPTH(NUM_ARCH_REGS), .DW(PW), .NW(CMT_WIDTH), .NR(RESTORE_LANES), .AW(AW)) u_rrat (
    .clk(clk), .rst(rst),
    .we_i(rrat_we), .waddr_i(rrat_waddr), .wdata_i(rrat_wdata),
    .raddr_i(rrat_raddr), .rdata_o(rrat_rdata)
  );

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    case (state_q)
      RS_IDLE: begin
        if (bus.flush_i) begin
          state_d = RS_RESTORE;
          blk_d   = '0;
        end
      end
      RS_RESTORE: begin
        if (bus.flush_i) begin
          blk_d = '0;
        end else if (blk_q == BW'(NBLK - 1)) begin
          state_d = RS_IDLE;
          blk_d   = '0;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      default: begin
        state_d = RS_IDLE;
        blk_d   = '0;
      end
    endcase
  end

  // Unaccepted slots register zeros; accept is already low in a flush cycle.
  always_comb begin
    out_valid_d = accept;
    rs1_d       = '0;
    rs2_d       = '0;
    old_d       = '0;
    for (int s = 0; s < WIDTH; s++) begin
      if (accept[s]) begin
        rs1_d[s] = rs1_map[s];
        rs2_d[s] = rs2_map[s];
        old_d[s] = old_map[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RS_IDLE;
      blk_q       <= '0;
      out_valid_q <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      old_q       <= '0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      old_q       <= old_d;
    end
  end

  assign bus.ren_accept_o    = accept;
  assign bus.ren_out_valid_o = out_valid_q;
  assign bus.ren_rs1_phys_o  = rs1_q;
  assign bus.ren_rs2_phys_o  = rs2_q;
  assign bus.ren_old_phys_o  = old_q;
  assign bus.restore_busy_o  = restoring;
endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: vector table for renames, hand sequences for commit/flush/restore/reset.
module tb_rename_map_table;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_map_table_if #(.WIDTH(2), .CMT_WIDTH(2)) bus ();

  rename_map_table #(.WIDTH(2), .CMT_WIDTH(2), .RESTORE_LANES(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

`ifdef RENAME_INTRA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int RESTORE_CYC = NUM_ARCH_REGS / 8;

  typedef struct {
    logic [1:0] valid, we, acc;
    int rd[2], rdp[2], rs1[2], rs2[2], e1[2], e2[2], eo[2];
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;
  int n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.ren_valid_i    = '0;
    bus.ren_rd_we_i    = '0;
    bus.ren_rd_arch_i  = '0;
    bus.ren_rd_phys_i  = '0;
    bus.ren_rs1_arch_i = '0;
    bus.ren_rs2_arch_i = '0;
    bus.cmt_valid_i    = '0;
    bus.cmt_arch_i     = '0;
    bus.cmt_phys_i     = '0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic add(input logic [1:0] valid, input logic [1:0] we,
                     input int rd0, input int rd1, input int p0, input int p1,
                     input int a0, input int a1, input int b0, input int b1,
                     input logic [1:0] acc,
                     input int e10, input int e11, input int e20, input int e21,
                     input int eo0, input int eo1);
    vec_t v;
    v.valid = valid; v.we = we; v.acc = acc;
    v.rd[0] = rd0;  v.rd[1] = rd1;  v.rdp[0] = p0;  v.rdp[1] = p1;
    v.rs1[0] = a0;  v.rs1[1] = a1;  v.rs2[0] = b0;  v.rs2[1] = b1;
    v.e1[0] = e10;  v.e1[1] = e11;  v.e2[0] = e20;  v.e2[1] = e21;
    v.eo[0] = eo0;  v.eo[1] = eo1;
    vecs.push_back(v);
  endtask

  task automatic lookup(input int arch, input int exp, input string name);
    @(negedge clk);
    clr_in();
    bus.ren_valid_i       = 2'b01;
    bus.ren_rs1_arch_i[0] = areg_t'(arch);
    bus.ren_rs2_arch_i[0] = areg_t'(arch);
    @(posedge clk); #1;
    chk(name, 32'(bus.ren_rs1_phys_o[0]), exp);
    clr_in();
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.restore_busy_o && cyc < 20) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus.restore_busy_o),  0);
    chk("rst_outv",  32'(bus.ren_out_valid_o), 0);
    chk("rst_rs1",   32'(bus.ren_rs1_phys_o),  0);
    chk("rst_rs2",   32'(bus.ren_rs2_phys_o),  0);
    chk("rst_old",   32'(bus.ren_old_phys_o),  0);
    @(negedge clk);
    rst = 1'b0;

    // valid, we, rd0,rd1, p0,p1, rs1 0/1, rs2 0/1, accept, exp rs1 0/1, rs2 0/1, old 0/1
    add(2'b01, 2'b00,  0,  0,  0,  0,  3, 0,  4,  0, 2'b01,               3, 0,            4, 0,           0, 0);
    add(2'b11, 2'b11,  5,  5, 40, 41,  1, 5,  2,  6, BYP ? 2'b11 : 2'b01, 1, BYP ? 40 : 0, 2, BYP ? 6 : 0, 5, BYP ? 40 : 0);
    add(2'b01, 2'b01,  5,  0, 41,  0,  5, 0,  6,  0, 2'b01,  BYP ? 41 : 40, 0,            6, 0, BYP ? 41 : 40, 0);
    add(2'b11, 2'b01,  9,  0, 42,  0,  5, 9,  9, 10, BYP ? 2'b11 : 2'b01, 41, BYP ? 42 : 0, 9, BYP ? 10 : 0, 9, 0);
    add(2'b10, 2'b10,  0, 11,  0, 43,  0, 9,  0,  5, 2'b10,               0, 42,           0, 41,          0, 11);
    add(2'b11, 2'b11, 12, 12, 44, 45,  0, 0,  0,  0, BYP ? 2'b11 : 2'b01, 0, 0,            0, 0,          12, BYP ? 44 : 0);
    add(2'b01, 2'b00,  0,  0,  0,  0, 12, 0, 11,  0, 2'b01,  BYP ? 45 : 44, 0,           43, 0,           0, 0);
    add(2'b11, 2'b00, 13,  0,  0,  0,  0, 13, 0,  0, 2'b11,               0, 13,           0, 0,          13, 0);
    add(2'b00, 2'b00,  0,  0,  0,  0,  0, 0,  0,  0, 2'b00,               0, 0,            0, 0,           0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      clr_in();
      bus.ren_valid_i = vecs[i].valid;
      bus.ren_rd_we_i = vecs[i].we;
      for (int s = 0; s < 2; s++) begin
        bus.ren_rd_arch_i[s]  = areg_t'(vecs[i].rd[s]);
        bus.ren_rd_phys_i[s]  = preg_t'(vecs[i].rdp[s]);
        bus.ren_rs1_arch_i[s] = areg_t'(vecs[i].rs1[s]);
        bus.ren_rs2_arch_i[s] = areg_t'(vecs[i].rs2[s]);
      end
      #1;
      chk($sformatf("v%0d_accept", i), 32'(bus.ren_accept_o), 32'(vecs[i].acc));
      @(posedge clk); #1;
      chk($sformatf("v%0d_outv", i), 32'(bus.ren_out_valid_o), 32'(vecs[i].acc));
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("v%0d_rs1_s%0d", i, s), 32'(bus.ren_rs1_phys_o[s]), vecs[i].e1[s]);
        chk($sformatf("v%0d_rs2_s%0d", i, s), 32'(bus.ren_rs2_phys_o[s]), vecs[i].e2[s]);
        chk($sformatf("v%0d_old_s%0d", i, s), 32'(bus.ren_old_phys_o[s]), vecs[i].eo[s]);
      end
    end

    // Duplicate commit in one cycle, then flush with a rename in the same cycle.
    @(negedge clk);
    clr_in();
    bus.cmt_valid_i   = 2'b11;
    bus.cmt_arch_i[0] = areg_t'(1); bus.cmt_phys_i[0] = preg_t'(50);
    bus.cmt_arch_i[1] = areg_t'(1); bus.cmt_phys_i[1] = preg_t'(51);
    @(negedge clk);
    clr_in();
    bus.flush_i           = 1'b1;
    bus.ren_valid_i       = 2'b01;
    bus.ren_rs1_arch_i[0] = areg_t'(1);
    #1;
    chk("flush_accept", 32'(bus.ren_accept_o), 0);
    @(posedge clk); #1;
    clr_in();
    chk("flush_squash", 32'(bus.ren_out_valid_o), 0);
    chk("busy_start",   32'(bus.restore_busy_o),  1);
    wait_idle(n);
    chk("restore_len", n, RESTORE_CYC);
    lookup(1, 51, "a1_after_restore");
    lookup(5, 5,  "a5_spec_dropped");
    lookup(9, 9,  "a9_spec_dropped");

    // Commits during restore: a2 already copied, a20 not yet copied.
    @(negedge clk);
    clr_in();
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(posedge clk); #1;
    bus.cmt_valid_i   = 2'b11;
    bus.cmt_arch_i[0] = areg_t'(2);  bus.cmt_phys_i[0] = preg_t'(60);
    bus.cmt_arch_i[1] = areg_t'(20); bus.cmt_phys_i[1] = preg_t'(61);
    bus.ren_valid_i       = 2'b01;
    bus.ren_rs1_arch_i[0] = areg_t'(2);
    #1;
    chk("restore_accept", 32'(bus.ren_accept_o), 0);
    @(posedge clk); #1;
    clr_in();
    chk("restore_outv", 32'(bus.ren_out_valid_o), 0);
    wait_idle(n);
    chk("restore_rest_len", n, RESTORE_CYC - 2);
    lookup(2,  60, "a2_commit_copied");
    lookup(20, 61, "a20_commit_pending");
    lookup(1,  51, "a1_kept");

    // Re-flush two blocks into a restore.
    @(negedge clk);
    clr_in();
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    wait_idle(n);
    chk("reflush_len", n, RESTORE_CYC);
    lookup(2, 60, "a2_after_reflush");

    // Speculative rename, then reset in the middle of a restore.
    @(negedge clk);
    clr_in();
    bus.ren_valid_i      = 2'b01;
    bus.ren_rd_we_i      = 2'b01;
    bus.ren_rd_arch_i[0] = areg_t'(3);
    bus.ren_rd_phys_i[0] = preg_t'(33);
    @(posedge clk); #1;
    clr_in();
    lookup(3, 33, "a3_spec");
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.restore_busy_o),  0);
    chk("midrst_outv", 32'(bus.ren_out_valid_o), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("postrst_busy", 32'(bus.restore_busy_o), 0);
    lookup(1,  1,  "ident_a1");
    lookup(2,  2,  "ident_a2");
    lookup(3,  3,  "ident_a3");
    lookup(20, 20, "ident_a20");
    lookup(31, 31, "ident_a31");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
